// File: rtl/bridge_pkg.sv
// Shared types and default address map for the CPU data-bus bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bridge_pkg;

    // Bridge transaction states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Default address map: data memory and two timer blocks
    localparam logic [31:0] DM_BASE      = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT     = 32'h0000_2FFF;
    localparam logic [31:0] TIMER0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] TIMER0_LIMIT = 32'h0000_7F0B;
    localparam logic [31:0] TIMER1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] TIMER1_LIMIT = 32'h0000_7F1B;

    // Device channel indices in the default map
    localparam int DEV_DM     = 0;
    localparam int DEV_TIMER0 = 1;
    localparam int DEV_TIMER1 = 2;

    localparam int DEFAULT_NUM_DEV = 3;

    // Flattened windows, channel 0 in the LSBs
    localparam logic [32*DEFAULT_NUM_DEV-1:0] DEFAULT_DEV_BASE  = {TIMER1_BASE,  TIMER0_BASE,  DM_BASE};
    localparam logic [32*DEFAULT_NUM_DEV-1:0] DEFAULT_DEV_LIMIT = {TIMER1_LIMIT, TIMER0_LIMIT, DM_LIMIT};

    // Width of a channel index; a single channel still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bridge_addr_decoder.sv
// Maps a byte address onto one of NUM_DEV inclusive windows, lowest index wins.
// Latency: purely combinational.
// Backpressure: none; output follows the address every cycle.
module bridge_addr_decoder
    import bridge_pkg::*;
#(
    parameter int                     NUM_DEV   = DEFAULT_NUM_DEV,
    parameter logic [32*NUM_DEV-1:0]  DEV_BASE  = DEFAULT_DEV_BASE,
    parameter logic [32*NUM_DEV-1:0]  DEV_LIMIT = DEFAULT_DEV_LIMIT,
    parameter int                     IDX_W     = idx_width(NUM_DEV)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest matching window is the one left in idx
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if ((addr >= DEV_BASE[32*k +: 32]) && (addr <= DEV_LIMIT[32*k +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/sys_bus_bridge.sv
// Registered CPU-to-peripheral bridge: decodes, strobes one device, returns data/error.
// Latency: accept T, dev_sel T+1, rsp_valid T+2 at best, T+1+TIMEOUT on timeout.
// Backpressure: req_ready only in IDLE; device stalls extend ACCESS up to TIMEOUT cycles.
module sys_bus_bridge
    import bridge_pkg::*;
#(
    parameter int                     NUM_DEV   = DEFAULT_NUM_DEV,
    parameter logic [32*NUM_DEV-1:0]  DEV_BASE  = DEFAULT_DEV_BASE,
    parameter logic [32*NUM_DEV-1:0]  DEV_LIMIT = DEFAULT_DEV_LIMIT,
    parameter int                     TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [3:0]             req_byteen,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [NUM_DEV-1:0]     dev_sel,
    output logic [31:0]            dev_addr,
    output logic [31:0]            dev_wdata,
    output logic [4*NUM_DEV-1:0]   dev_byteen,
    input  logic [32*NUM_DEV-1:0]  dev_rdata,
    input  logic [NUM_DEV-1:0]     dev_ready
);

    localparam int IDX_W = idx_width(NUM_DEV);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        byteen_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;

    logic              sel_ready;
    logic [31:0]       sel_rdata;

    logic              load_req;
    logic              load_rsp;
    logic [31:0]       rsp_rdata_d;
    logic              rsp_err_d;
    logic              cnt_clr;
    logic              cnt_inc;

    bridge_addr_decoder #(
        .NUM_DEV   (NUM_DEV),
        .DEV_BASE  (DEV_BASE),
        .DEV_LIMIT (DEV_LIMIT),
        .IDX_W     (IDX_W)
    ) u_dec (
        .addr (req_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the latched channel's handshake and data are ever looked at
    assign sel_ready = dev_ready[idx_q];
    assign sel_rdata = dev_rdata[32*int'(idx_q) +: 32];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    // Device strobe and byte lanes exist only while in ACCESS, so a reset drops them at once
    always_comb begin
        dev_sel    = '0;
        dev_byteen = '0;
        if (state_q == ACCESS) begin
            dev_sel[idx_q]                     = 1'b1;
            dev_byteen[4*int'(idx_q) +: 4]     = byteen_q;
        end
    end

    // Next-state and datapath load controls
    always_comb begin
        state_d     = state_q;
        load_req    = 1'b0;
        load_rsp    = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_clr  = 1'b1;
                    load_req = dec_hit;
                    state_d  = dec_hit ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                // A ready on the last allowed cycle still wins over the timeout
                if (sel_ready) begin
                    load_rsp    = 1'b1;
                    rsp_rdata_d = sel_rdata;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    load_rsp  = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                load_rsp  = 1'b1;
                rsp_err_d = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch: address, data, lanes and channel held for the whole access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dev_addr  <= '0;
            dev_wdata <= '0;
            byteen_q  <= '0;
            idx_q     <= '0;
        end else if (load_req) begin
            dev_addr  <= req_addr;
            dev_wdata <= req_wdata;
            byteen_q  <= req_byteen;
            idx_q     <= dec_idx;
        end
    end

    // Response registers hold until the next response is loaded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (load_rsp) begin
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Wait-cycle counter for the device timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Scoreboard bench for sys_bus_bridge: directed transactions push expected responses,
// a negedge monitor pops and compares whenever rsp_valid is seen.
// Per-cycle strobe/lane checks are made by the stimulus task while the access runs.
module tb_sys_bus_bridge;

    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_byteen = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [2:0]   dev_sel;
    logic [31:0]  dev_addr;
    logic [31:0]  dev_wdata;
    logic [11:0]  dev_byteen;
    logic [95:0]  dev_rdata = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    logic [2:0]   dev_ready = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;

    sys_bus_bridge #(
        .NUM_DEV (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_byteen (req_byteen),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dev_sel    (dev_sel),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_byteen (dev_byteen),
        .dev_rdata  (dev_rdata),
        .dev_ready  (dev_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                m_e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, m_e.rdata);
                chk("rsp_err",   rsp_err,   m_e.err);
                chk("rsp_cycle", cyc,       m_e.at);
            end
        end
    end

    // One transaction. Caller sits on a negedge. dev<0 means unmapped; ready_at is the
    // cycle after accept on which the device answers (0 = never). Returns the accept cycle.
    task automatic xact(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input int dev, input int ready_at, input logic [31:0] dev_data,
                        input logic noise, input int lat, input logic [31:0] exp_rdata,
                        input logic exp_err, output int acc);
        int guard;
        exp_t e;
        logic [2:0]  sel_exp;
        logic [11:0] be_exp;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc;
        if (req_ready !== 1'b1) begin
            chk("req_ready_wait", 0, 1);
            return;
        end
        sel_exp = '0;
        be_exp  = '0;
        if (dev >= 0) begin
            sel_exp[dev]          = 1'b1;
            be_exp[4*dev +: 4]    = be;
        end
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_byteen = be;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.at    = acc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'h5555_AAAA;
        for (int i = 1; i < lat; i++) begin
            chk("req_ready_busy", req_ready, 0);
            chk("dev_sel",        dev_sel,    sel_exp);
            chk("dev_byteen",     dev_byteen, be_exp);
            if (dev >= 0) begin
                chk("dev_addr",  dev_addr,  addr);
                chk("dev_wdata", dev_wdata, wdata);
            end
            dev_ready = noise ? ~sel_exp : 3'b000;
            if (dev >= 0) begin
                if (i == ready_at) begin
                    dev_ready[dev]          = 1'b1;
                    dev_rdata[32*dev +: 32] = dev_data;
                end else begin
                    dev_rdata[32*dev +: 32] = 32'hBAD0_0000 | i;
                end
            end
            @(negedge clk);
        end
        dev_ready = '0;
        chk("req_ready_resp", req_ready, 0);
        chk("dev_sel_resp",   dev_sel,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3;
        // Reset state while held
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  req_ready,  1);
        chk("rst_rsp_valid",  rsp_valid,  0);
        chk("rst_rsp_rdata",  rsp_rdata,  0);
        chk("rst_rsp_err",    rsp_err,    0);
        chk("rst_dev_sel",    dev_sel,    0);
        chk("rst_dev_byteen", dev_byteen, 0);
        chk("rst_dev_addr",   dev_addr,   0);
        chk("rst_dev_wdata",  dev_wdata,  0);
        reset = 1'b1;
        @(negedge clk);

        // Read DM, zero wait
        xact(32'h0000_1004, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, a0);
        @(negedge clk);
        chk("rsp_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("idle_after_read", req_ready, 1);

        // Write TIMER1, two wait states, other channels waving ready
        xact(32'h0000_7F14, 32'h0000_00FF, 4'hF, 2, 3, 32'hA5A5_0001, 1'b1, 4, 32'hA5A5_0001, 1'b0, a0);

        // Unmapped hole between the timers
        xact(32'h0000_7F0C, 32'h1234_5678, 4'hF, -1, 0, 32'h0, 1'b1, 2, 32'h0, 1'b1, a0);

        // Timeout on TIMER0
        xact(32'h0000_7F00, 32'h0, 4'h0, 1, 0, 32'h0, 1'b1, 16, 32'h0, 1'b1, a0);
        @(negedge clk);
        chk("idle_after_timeout", req_ready, 1);

        // Ready exactly on the last allowed cycle is a success
        xact(32'h0000_7F08, 32'h0, 4'h0, 1, 15, 32'h0BAD_F00D, 1'b0, 16, 32'h0BAD_F00D, 1'b0, a0);

        // Reset two cycles into a TIMER0 access
        @(negedge clk);
        chk("pre_rst_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = 32'h0000_7F04;
        req_byteen = 4'h3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_dev_sel",    dev_sel,    3'b010);
        chk("mid_dev_byteen", dev_byteen, 12'h030);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_dev_sel",    dev_sel,    0);
        chk("async_dev_byteen", dev_byteen, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        chk("post_rst_no_rsp", rsp_valid, 0);

        // Next read completes normally
        xact(32'h0000_0000, 32'h0, 4'h0, 0, 1, 32'h0000_0042, 1'b0, 2, 32'h0000_0042, 1'b0, a0);

        // Window edges, back to back
        xact(32'h0000_2FFF, 32'h0, 4'h0, 0, 1, 32'h1111_2222, 1'b0, 2, 32'h1111_2222, 1'b0, a1);
        xact(32'h0000_3000, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0, 2, 32'h0, 1'b1, a2);
        xact(32'h0000_7F0B, 32'h0, 4'h0, 1, 1, 32'h3333_4444, 1'b0, 2, 32'h3333_4444, 1'b0, a3);
        chk("b2b_gap_1", a2 - a1, 3);
        chk("b2b_gap_2", a3 - a2, 3);
        xact(32'h0000_7F1B, 32'hFFFF_0000, 4'hC, 2, 1, 32'h5555_6666, 1'b0, 2, 32'h5555_6666, 1'b0, a1);
        chk("b2b_gap_3", a1 - a3, 3);
        xact(32'h0000_7F1C, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0, 2, 32'h0, 1'b1, a0);
        xact(32'hFFFF_FFFF, 32'h0, 4'h1, -1, 0, 32'h0, 1'b0, 2, 32'h0, 1'b1, a0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
